// File: rtl/blink_sched.sv
// blink_sched: shares one LED blink engine between NREQ requesters.
// Requesters are arbitrated round-robin. The owner's burst of N blinks is
// sequenced from a free-running prescaler tick, followed by a dark gap and
// a one-cycle done pulse.
//
// Ports:
//   clk    - clock, all state on posedge
//   rst    - asynchronous active-low reset
//   req    - per-requester request level, held until done or grant drops
//   nblink - per-requester blink counts, slice i at [i*NBITS +: NBITS]
//   grant  - one-hot engine owner, zero when idle
//   done   - one-cycle completion pulse to the owner
//   led    - LED drive
//   flg    - registered prescaler tick
//   busy   - high whenever grant is nonzero
module blink_sched #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned CBITS     = 25,
   parameter int unsigned NBITS     = 4,
   parameter int unsigned GAP_TICKS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*NBITS-1:0] nblink,
   output logic [NREQ-1:0]       grant,
   output logic [NREQ-1:0]       done,
   output logic                  led,
   output logic                  flg,
   output logic                  busy
);

   localparam int unsigned OW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned OW1 = OW + 1;
   localparam int unsigned GW  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_ON,
      S_OFF,
      S_GAP,
      S_DONE
   } state_t;

   state_t            state, state_n;
   logic [CBITS-1:0]  cnt, cnt_n;
   logic [OW-1:0]     rr_ptr, rr_n;
   logic [OW-1:0]     owner, owner_n;
   logic [NBITS-1:0]  count, count_n;
   logic [NBITS-1:0]  remaining, rem_n;
   logic [GW-1:0]     gap, gap_n;
   logic [NREQ-1:0]   grant_n, done_n;
   logic              led_n, flg_n, busy_n;

   logic              tick;
   logic              pick_valid;
   logic [OW-1:0]     pick_idx;
   logic [OW1-1:0]    scan;
   logic [OW-1:0]     next_rr;
   logic              abort;

   assign tick    = &cnt;
   assign next_rr = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
   assign abort   = ~req[owner];

   // Round-robin pick: scanning offsets high to low leaves the lowest offset
   // from rr_ptr as the winner.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      scan       = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         scan = OW1'(rr_ptr) + OW1'(i);
         if (scan >= OW1'(NREQ)) scan = scan - OW1'(NREQ);
         if (req[scan[OW-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = scan[OW-1:0];
         end
      end
   end

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         rr_ptr    <= '0;
         owner     <= '0;
         count     <= '0;
         remaining <= '0;
         gap       <= '0;
         grant     <= '0;
         done      <= '0;
         led       <= 1'b0;
         flg       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         rr_ptr    <= rr_n;
         owner     <= owner_n;
         count     <= count_n;
         remaining <= rem_n;
         gap       <= gap_n;
         grant     <= grant_n;
         done      <= done_n;
         led       <= led_n;
         flg       <= flg_n;
         busy      <= busy_n;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_n = state;
      cnt_n   = cnt + CBITS'(1);
      flg_n   = tick;
      rr_n    = rr_ptr;
      owner_n = owner;
      count_n = count;
      rem_n   = remaining;
      gap_n   = gap;
      grant_n = grant;
      done_n  = '0;
      led_n   = led;
      busy_n  = busy;

      case (state)
         S_IDLE: begin
            led_n = 1'b0;
            if (pick_valid) begin
               grant_n = NREQ'(1) << pick_idx;
               busy_n  = 1'b1;
               owner_n = pick_idx;
               count_n = nblink[pick_idx*NBITS +: NBITS];
               state_n = S_SYNC;
            end
         end

         S_DONE: begin
            grant_n = '0;
            busy_n  = 1'b0;
            led_n   = 1'b0;
            rr_n    = next_rr;
            state_n = S_IDLE;
         end

         default: begin
            if (abort) begin
               // Owner withdrew: release without a done pulse; beats any tick.
               state_n = S_IDLE;
               led_n   = 1'b0;
               grant_n = '0;
               busy_n  = 1'b0;
               rr_n    = next_rr;
            end else begin
               case (state)
                  S_SYNC: begin
                     // Zero-length burst finishes one cycle after the grant.
                     if (count == '0) begin
                        state_n = S_DONE;
                        done_n  = grant;
                     end else if (tick) begin
                        state_n = S_ON;
                        led_n   = 1'b1;
                        rem_n   = count;
                     end
                  end
                  S_ON: begin
                     if (tick) begin
                        state_n = S_OFF;
                        led_n   = 1'b0;
                     end
                  end
                  S_OFF: begin
                     if (tick) begin
                        rem_n = remaining - NBITS'(1);
                        if (remaining == NBITS'(1)) begin
                           if (GAP_TICKS == 0) begin
                              state_n = S_DONE;
                              done_n  = grant;
                           end else begin
                              state_n = S_GAP;
                              gap_n   = GW'(GAP_TICKS);
                           end
                        end else begin
                           state_n = S_ON;
                           led_n   = 1'b1;
                        end
                     end
                  end
                  S_GAP: begin
                     led_n = 1'b0;
                     if (tick) begin
                        gap_n = gap - GW'(1);
                        if (gap == GW'(1)) begin
                           state_n = S_DONE;
                           done_n  = grant;
                        end
                     end
                  end
                  default: state_n = S_IDLE;
               endcase
            end
         end
      endcase
   end

endmodule

// File: tb/tb_blink_sched.sv
// Bench for blink_sched with CBITS=3 (tick every 8 cycles), NREQ=4,
// NBITS=4, GAP_TICKS=2.
module tb_blink_sched;

   localparam int unsigned NREQ      = 4;
   localparam int unsigned CBITS     = 3;
   localparam int unsigned NBITS     = 4;
   localparam int unsigned GAP_TICKS = 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*NBITS-1:0] nblink = '0;
   logic [NREQ-1:0]       grant, done;
   logic                  led, flg, busy;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [NREQ-1:0] req;
      logic [NREQ-1:0] exp_grant;
   } vec_t;

   vec_t tbl[11];

   blink_sched #(
      .NREQ(NREQ), .CBITS(CBITS), .NBITS(NBITS), .GAP_TICKS(GAP_TICKS)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .nblink(nblink),
      .grant(grant), .done(done), .led(led), .flg(flg), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst    = 1'b0;
      req    = '0;
      nblink = '0;
      cyc();
      cyc();
      rst = 1'b1;
   endtask

   // Samples while led stays at lvl; starts on a sample already at lvl.
   task automatic run_len(input logic lvl, output int n);
      n = 1;
      for (int k = 0; k < 100; k++) begin
         cyc();
         if (led !== lvl) break;
         n++;
      end
   endtask

   task automatic wait_led(input logic lvl);
      for (int k = 0; k < 40 && led !== lvl; k++) cyc();
   endtask

   initial begin
      int n, first_flg, n_flg, rises, hi;
      logic prev;
      logic [NREQ-1:0] rr_exp[5];

      tbl[0]  = '{4'b1111, 4'b0001};
      tbl[1]  = '{4'b1111, 4'b0010};
      tbl[2]  = '{4'b1111, 4'b0100};
      tbl[3]  = '{4'b1111, 4'b1000};
      tbl[4]  = '{4'b1111, 4'b0001};
      tbl[5]  = '{4'b0001, 4'b0001};
      tbl[6]  = '{4'b1100, 4'b0100};
      tbl[7]  = '{4'b0110, 4'b0010};
      tbl[8]  = '{4'b1001, 4'b1000};
      tbl[9]  = '{4'b0100, 4'b0100};
      tbl[10] = '{4'b0101, 4'b0001};
      rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      // Reset state
      #2 rst = 1'b0;
      #1;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_led", 32'(led), 0);
      chk("rst_flg", 32'(flg), 0);
      chk("rst_busy", 32'(busy), 0);
      cyc();
      cyc();
      rst = 1'b1;

      // Prescaler flag: first high on sample 8, then every 8 cycles
      first_flg = -1;
      n_flg = 0;
      for (int k = 1; k <= 40; k++) begin
         cyc();
         if (flg === 1'b1) begin
            if (first_flg < 0) first_flg = k;
            n_flg++;
         end
      end
      chk("flg_first", 32'(first_flg), 8);
      chk("flg_count", 32'(n_flg), 5);

      // Single 3-blink burst with gap
      do_reset();
      req    = 4'b0001;
      nblink = 16'h0003;
      cyc();
      chk("a_grant", 32'(grant), 32'h1);
      chk("a_busy", 32'(busy), 1);
      wait_led(1'b1);
      chk("a_led_rise", 32'(led), 1);
      chk("a_flg_rise", 32'(flg), 1);
      for (int p = 0; p < 3; p++) begin
         run_len(1'b1, n);
         chk("a_hi_len", 32'(n), 8);
         chk("a_flg_fall", 32'(flg), 1);
         if (p < 2) begin
            run_len(1'b0, n);
            chk("a_lo_len", 32'(n), 8);
            chk("a_flg_rise2", 32'(flg), 1);
         end
      end
      n = 0;
      hi = 0;
      for (int k = 0; k < 60; k++) begin
         cyc();
         n++;
         if (led === 1'b1) hi++;
         if (done !== '0) break;
      end
      chk("a_done_lat", 32'(n), 24);
      chk("a_gap_dark", 32'(hi), 0);
      chk("a_done", 32'(done), 32'h1);
      chk("a_grant_at_done", 32'(grant), 32'h1);
      cyc();
      chk("a_grant_off", 32'(grant), 0);
      chk("a_done_off", 32'(done), 0);
      chk("a_busy_off", 32'(busy), 0);
      req = '0;

      // Zero-count table: grant, done one cycle later, release
      do_reset();
      for (int v = 0; v < 11; v++) begin
         req = tbl[v].req;
         cyc();
         chk($sformatf("t%0d_grant", v), 32'(grant), 32'(tbl[v].exp_grant));
         chk($sformatf("t%0d_busy", v), 32'(busy), 1);
         cyc();
         chk($sformatf("t%0d_done", v), 32'(done), 32'(tbl[v].exp_grant));
         chk($sformatf("t%0d_led", v), 32'(led), 0);
         req = '0;
         cyc();
         chk($sformatf("t%0d_release", v), 32'({busy, grant}), 0);
      end

      // Round robin, count 1 each, requests held
      do_reset();
      nblink = 16'h1111;
      req    = 4'b1111;
      cyc();
      for (int b = 0; b < 5; b++) begin
         chk($sformatf("b%0d_grant", b), 32'(grant), 32'(rr_exp[b]));
         rises = 0;
         hi = 0;
         prev = 1'b0;
         for (int k = 0; k < 100; k++) begin
            cyc();
            if (led === 1'b1) hi++;
            if (led === 1'b1 && !prev) rises++;
            prev = led;
            if (done !== '0) break;
         end
         chk($sformatf("b%0d_done", b), 32'(done), 32'(rr_exp[b]));
         chk($sformatf("b%0d_pulses", b), 32'(rises), 1);
         chk($sformatf("b%0d_hi", b), 32'(hi), 8);
         cyc();
         chk($sformatf("b%0d_idle", b), 32'(grant), 0);
         cyc();
      end
      req = '0;

      // Abort during second ON phase; pending requester 2 follows
      do_reset();
      nblink = 16'h0050;
      req    = 4'b0110;
      cyc();
      chk("c_grant", 32'(grant), 32'h2);
      wait_led(1'b1);
      run_len(1'b1, n);
      run_len(1'b0, n);
      cyc();
      cyc();
      chk("c_led_on2", 32'(led), 1);
      req = 4'b0100;
      cyc();
      chk("c_abort_led", 32'(led), 0);
      chk("c_abort_grant", 32'(grant), 0);
      chk("c_abort_busy", 32'(busy), 0);
      chk("c_abort_done", 32'(done), 0);
      cyc();
      chk("c_next_grant", 32'(grant), 32'h4);
      chk("c_no_done", 32'(done), 0);
      req = '0;

      // Async reset mid-ON, then arbitration restarts at requester 0
      do_reset();
      nblink = 16'h0300;
      req    = 4'b0100;
      cyc();
      chk("d_grant", 32'(grant), 32'h4);
      wait_led(1'b1);
      cyc();
      cyc();
      chk("d_led_on", 32'(led), 1);
      rst = 1'b0;
      #1;
      chk("d_rst_led", 32'(led), 0);
      chk("d_rst_grant", 32'(grant), 0);
      chk("d_rst_busy", 32'(busy), 0);
      #2;
      rst = 1'b1;
      req = 4'b1010;
      cyc();
      chk("d_grant_after", 32'(grant), 32'h2);
      req = '0;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
